// File: rtl/rank_filter_ctrl_if.sv
// Handshake and datapath bundle for rank_filter_ctrl.
//   cfg_*   : configuration offer (mask, 1-based target rank), reject pulse
//   in_*    : sample stream input
//   shift_en, win_clr, dp_mask, ranks_in : masked-rank datapath control/readback
//   out_*   : selected sample result, held until accepted
// master = the controller, slave = its environment (source, datapath, consumer).
interface rank_filter_ctrl_if #(
   parameter int N         = 7,
   parameter int DATA_W    = 8,
   parameter int RANK_BITS = $clog2(N+1)
) ();
   logic                   cfg_valid;
   logic                   cfg_ready;
   logic [N-1:0]           cfg_mask;
   logic [RANK_BITS-1:0]   cfg_rank;
   logic                   cfg_err;
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_W-1:0]      in_data;
   logic                   shift_en;
   logic                   win_clr;
   logic [N-1:0]           dp_mask;
   logic [RANK_BITS*N-1:0] ranks_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_W-1:0]      out_data;
   logic                   out_miss;
   logic [7:0]             out_seq;

   modport master (
      input  cfg_valid, cfg_mask, cfg_rank, in_valid, in_data, ranks_in, out_ready,
      output cfg_ready, cfg_err, in_ready, shift_en, win_clr, dp_mask,
             out_valid, out_data, out_miss, out_seq
   );

   modport slave (
      output cfg_valid, cfg_mask, cfg_rank, in_valid, in_data, ranks_in, out_ready,
      input  cfg_ready, cfg_err, in_ready, shift_en, win_clr, dp_mask,
             out_valid, out_data, out_miss, out_seq
   );
endinterface

// File: rtl/rank_filter_ctrl.sv
// Sequencer for the masked rank-order filter datapath. Accepts configuration
// and samples, strobes the datapath window (shift_en / win_clr), keeps a shadow
// copy of the window and, after every full-window shift, emits the shadow
// sample whose masked rank equals the target rank.
// Ports: clk, rst (async, active-low), bus (rank_filter_ctrl_if.master).
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_CFG  | waiting for a valid configuration; window not yet filled
// S_FILL | collecting N samples after a window clear
// S_EVAL | datapath ranks reflect the new window; pick the result
// S_OUT  | result presented, held until out_ready
// S_RUN  | steady state: one sample per result, config updates allowed
module rank_filter_ctrl #(
   parameter int N         = 7,
   parameter int DATA_W    = 8,
   parameter int RANK_BITS = $clog2(N+1)
) (
   input  logic               clk,
   input  logic               rst,
   rank_filter_ctrl_if.master bus
);

   typedef enum logic [2:0] {S_CFG, S_FILL, S_EVAL, S_OUT, S_RUN} state_t;

   state_t               state;
   logic [DATA_W-1:0]    shadow [N];
   logic [RANK_BITS-1:0] fill_cnt;
   logic [RANK_BITS-1:0] tgt_rank;
   logic [RANK_BITS-1:0] cfg_pop;
   logic                 cfg_ok;
   logic                 in_acc;
   logic                 hit;
   logic [DATA_W-1:0]    hit_data;

   always_comb begin
      cfg_pop = '0;
      for (int j = 0; j < N; j++) begin
         cfg_pop = cfg_pop + RANK_BITS'(bus.cfg_mask[j]);
      end
   end

   assign cfg_ok = (bus.cfg_rank != '0) && (bus.cfg_rank <= cfg_pop);

   // The first FILL cycle carries win_clr; holding off samples there keeps
   // shift_en and win_clr mutually exclusive. In RUN, config wins over samples.
   assign bus.cfg_ready = (state == S_CFG) || (state == S_RUN);
   assign bus.in_ready  = ((state == S_FILL) && !bus.win_clr) ||
                          ((state == S_RUN) && !bus.cfg_valid);
   assign in_acc        = bus.in_valid && bus.in_ready;
   assign bus.shift_en  = in_acc;

   // Descending scan so the lowest matching slot is the one left standing.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int j = N-1; j >= 0; j--) begin
         if (bus.dp_mask[j] && (bus.ranks_in[j*RANK_BITS +: RANK_BITS] == tgt_rank)) begin
            hit      = 1'b1;
            hit_data = shadow[j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_CFG;
         fill_cnt     <= '0;
         tgt_rank     <= '0;
         bus.dp_mask  <= '0;
         bus.win_clr  <= 1'b0;
         bus.cfg_err  <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data <= '0;
         bus.out_miss <= 1'b0;
         bus.out_seq  <= '0;
         for (int j = 0; j < N; j++) shadow[j] <= '0;
      end else begin
         bus.win_clr <= 1'b0;
         bus.cfg_err <= 1'b0;

         if (in_acc) begin
            for (int j = 0; j < N-1; j++) shadow[j] <= shadow[j+1];
            shadow[N-1] <= bus.in_data;
         end else if (bus.win_clr) begin
            for (int j = 0; j < N; j++) shadow[j] <= '0;
         end

         case (state)
            S_CFG: begin
               if (bus.cfg_valid) begin
                  if (cfg_ok) begin
                     bus.dp_mask <= bus.cfg_mask;
                     tgt_rank    <= bus.cfg_rank;
                     bus.win_clr <= 1'b1;
                     fill_cnt    <= '0;
                     state       <= S_FILL;
                  end else begin
                     bus.cfg_err <= 1'b1;
                  end
               end
            end
            S_FILL: begin
               if (in_acc) begin
                  fill_cnt <= fill_cnt + 1'b1;
                  if (fill_cnt == RANK_BITS'(N-1)) state <= S_EVAL;
               end
            end
            S_EVAL: begin
               bus.out_data  <= hit ? hit_data : '0;
               bus.out_miss  <= !hit;
               bus.out_valid <= 1'b1;
               state         <= S_OUT;
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.out_seq   <= bus.out_seq + 8'd1;
                  state         <= S_RUN;
               end
            end
            S_RUN: begin
               if (bus.cfg_valid) begin
                  if (cfg_ok) begin
                     bus.dp_mask <= bus.cfg_mask;
                     tgt_rank    <= bus.cfg_rank;
                  end else begin
                     bus.cfg_err <= 1'b1;
                  end
               end else if (in_acc) begin
                  state <= S_EVAL;
               end
            end
            default: state <= S_CFG;
         endcase
      end
   end

endmodule
